// File: rtl/mux_2in1.sv
// rtl/mux_2in1.sv - registered 2-to-1 operand select with capture enable
// Holds o_dat while the datapath stalls; o_valid marks the cycle after a capture.
module mux_2in1 #(
  parameter int WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  input  logic             i_control,
  input  logic [WIDTH-1:0] i_dat0,
  input  logic [WIDTH-1:0] i_dat1,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_valid
);

  logic [WIDTH-1:0] dat_q, dat_d;
  logic             valid_q, valid_d;

  // An unknown i_control falls through to the else path and picks i_dat0.
  always_comb begin
    dat_d   = dat_q;
    valid_d = 1'b0;
    if (i_en) begin
      valid_d = 1'b1;
      if (i_control) begin
        dat_d = i_dat1;
      end else begin
        dat_d = i_dat0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      dat_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      dat_q   <= dat_d;
      valid_q <= valid_d;
    end
  end

  assign o_dat   = dat_q;
  assign o_valid = valid_q;

endmodule

// File: tb/tb_mux_2in1.sv
// tb/tb_mux_2in1.sv - self-checking bench for mux_2in1
// Directed scenarios plus randomized traffic against a per-edge behavioural model.
module tb_mux_2in1;

  logic        clk;
  logic        rst;
  logic        en;
  logic        ctl;
  logic [31:0] d0;
  logic [31:0] d1;
  logic [31:0] o_dat;
  logic        o_valid;

  logic [31:0] exp_dat;
  logic        exp_valid;
  int          errors;
  int          checks;

  mux_2in1 #(.WIDTH(32)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_en     (en),
    .i_control(ctl),
    .i_dat0   (d0),
    .i_dat1   (d1),
    .o_dat    (o_dat),
    .o_valid  (o_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs, take one rising edge, then advance the model by the same edge.
  task automatic drive(input logic r, input logic e, input logic c,
                       input logic [31:0] a, input logic [31:0] b);
    rst = r;
    en  = e;
    ctl = c;
    d0  = a;
    d1  = b;
    @(posedge clk);
    #1;
    if (r) begin
      exp_dat   = 32'd0;
      exp_valid = 1'b0;
    end else if (e) begin
      exp_dat   = c ? b : a;
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic test_reset;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 1'b1, 1'b0, 32'd122, 32'd54);
      checks++;
      if (o_dat !== 32'd0 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset[%0d]: o_dat=%0d o_valid=%b expected 0/0", i, o_dat, o_valid);
      end
    end
    drive(1'b0, 1'b1, 1'b0, 32'd122, 32'd54);
    checks++;
    if (o_dat !== 32'd122 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_release: o_dat=%0d o_valid=%b expected 122/1", o_dat, o_valid);
    end
  endtask

  task automatic test_select0;
    logic [31:0] a[3] = '{32'd331, 32'd125, 32'd31};
    logic [31:0] b[3] = '{32'd20, 32'd574, 32'd290};
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, a[i], b[i]);
      checks++;
      if (o_dat !== a[i] || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL select0[%0d]: o_dat=%0d o_valid=%b expected %0d/1", i, o_dat, o_valid, a[i]);
      end
    end
  endtask

  task automatic test_select1;
    logic [31:0] a[4] = '{32'd62, 32'd90, 32'd98, 32'd9422};
    logic [31:0] b[4] = '{32'd5789, 32'd64, 32'd2546, 32'd876};
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 1'b1, 1'b1, a[i], b[i]);
      checks++;
      if (o_dat !== b[i] || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL select1[%0d]: o_dat=%0d o_valid=%b expected %0d/1", i, o_dat, o_valid, b[i]);
      end
    end
  endtask

  task automatic test_same_cycle;
    drive(1'b0, 1'b1, 1'b0, 32'd437, 32'd12);
    checks++;
    if (o_dat !== 32'd437) begin
      errors++;
      $display("FAIL same_cycle_a: o_dat=%0d expected 437", o_dat);
    end
    drive(1'b0, 1'b1, 1'b1, 32'd976, 32'd210);
    checks++;
    if (o_dat !== 32'd210) begin
      errors++;
      $display("FAIL same_cycle_b: o_dat=%0d expected 210", o_dat);
    end
  endtask

  task automatic test_hold;
    drive(1'b0, 1'b1, 1'b1, 32'd902, 32'd257);
    checks++;
    if (o_dat !== 32'd257 || o_valid !== 1'b1) begin
      errors++;
      $display("FAIL hold_capture: o_dat=%0d o_valid=%b expected 257/1", o_dat, o_valid);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, i[0], 32'd1, 32'd2);
      checks++;
      if (o_dat !== 32'd257 || o_valid !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: o_dat=%0d o_valid=%b expected 257/0", i, o_dat, o_valid);
      end
    end
  endtask

  task automatic test_width;
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if (o_dat !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL width_ones: o_dat=%h expected ffffffff", o_dat);
    end
    drive(1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if (o_dat !== 32'h0) begin
      errors++;
      $display("FAIL width_zero: o_dat=%h expected 00000000", o_dat);
    end
    drive(1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0);
    checks++;
    if (o_dat !== 32'h0 || o_valid !== 1'b0) begin
      errors++;
      $display("FAIL width_reset: o_dat=%h o_valid=%b expected 00000000/0", o_dat, o_valid);
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(1)), $urandom, $urandom);
      checks++;
      if (o_dat !== exp_dat || o_valid !== 1'b1) begin
        errors++;
        $display("FAIL back_to_back[%0d]: o_dat=%h o_valid=%b expected %h/1", i, o_dat, o_valid, exp_dat);
      end
    end
  endtask

  // Inputs wiggled between edges must not reach o_dat.
  task automatic test_between_edges;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b1, 1'($urandom_range(1)), $urandom, $urandom);
      d0  = $urandom;
      d1  = $urandom;
      ctl = ~ctl;
      #3;
      checks++;
      if (o_dat !== exp_dat || o_valid !== exp_valid) begin
        errors++;
        $display("FAIL between_edges[%0d]: o_dat=%h o_valid=%b expected %h/%b", i, o_dat, o_valid, exp_dat, exp_valid);
      end
    end
  endtask

  task automatic test_random;
    for (int i = 0; i < 200; i++) begin
      drive(($urandom_range(15) == 0), 1'($urandom_range(1)), 1'($urandom_range(1)),
            $urandom, $urandom);
      checks++;
      if (o_dat !== exp_dat || o_valid !== exp_valid) begin
        errors++;
        $display("FAIL random[%0d]: o_dat=%h o_valid=%b expected %h/%b", i, o_dat, o_valid, exp_dat, exp_valid);
      end
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    exp_dat   = 32'd0;
    exp_valid = 1'b0;
    rst = 1'b1;
    en  = 1'b0;
    ctl = 1'b0;
    d0  = 32'd0;
    d1  = 32'd0;
    test_reset;
    test_select0;
    test_select1;
    test_same_cycle;
    test_hold;
    test_width;
    test_back_to_back;
    test_between_edges;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
